// File: rtl/tx_link_pkg.sv
// ============================================================================
// Module      : tx_link_pkg
// Description : K-code symbols and sequencer state encoding for the TX link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_link_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame

  typedef enum logic [2:0] {
    ST_ALIGN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SOF   = 3'd2,
    ST_DATA  = 3'd3,
    ST_EOF   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tx_rr_arb2.sv
// ============================================================================
// Module      : tx_rr_arb2
// Description : Two-way round-robin arbiter; priority moves to the channel
//               that was not served whenever update is strobed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant
);

  // 0: ch0 holds priority, 1: ch1 holds priority
  logic r_pri;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pri <= 1'b0;
    end else if (update) begin
      r_pri <= ~served;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_pri ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tx_link_sequencer.sv
// ============================================================================
// Module      : tx_link_sequencer
// Description : Shares one 8b10b encoder between two byte requesters, framing
//               each granted burst with SOF/EOF and filling gaps with K28.5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_link_sequencer
  import tx_link_pkg::*;
#(
  parameter int ALIGN_LEN = 8,
  parameter int MAX_FRAME = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic [1:0] grant,
  output logic       link_up
);

  localparam int ALIGN_W = $clog2(ALIGN_LEN + 1);
  localparam int CNT_W   = $clog2(MAX_FRAME + 1);

  localparam logic [ALIGN_W-1:0] c_align_end = ALIGN_W'(ALIGN_LEN - 1);
  localparam logic [ALIGN_W-1:0] c_align_one = ALIGN_W'(1);
  localparam logic [CNT_W-1:0]   c_cnt_end   = CNT_W'(MAX_FRAME - 1);
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

  state_t               r_state;
  logic [ALIGN_W-1:0]   r_align_cnt;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [1:0]           r_grant;
  logic                 r_link_up;
  logic [7:0]           r_enc_data;
  logic                 r_enc_k;

  logic [1:0]           w_req;
  logic [1:0]           w_arb_grant;
  logic                 w_update;
  logic                 w_accept;
  logic [7:0]           w_sel_data;
  logic                 w_sel_last;

  assign w_req      = {req1_valid, req0_valid};
  assign w_update   = (r_state == ST_EOF);

  // Ready depends only on state and owner so a requester can never see
  // a combinational path from its own valid back to ready.
  assign req0_ready = (r_state == ST_DATA) && r_grant[0];
  assign req1_ready = (r_state == ST_DATA) && r_grant[1];

  assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_sel_data = r_grant[1] ? req1_data : req0_data;
  assign w_sel_last = r_grant[1] ? req1_last : req0_last;

  tx_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (w_req),
    .update (w_update),
    .served (r_grant[1]),
    .grant  (w_arb_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ALIGN;
      r_align_cnt <= '0;
      r_byte_cnt  <= '0;
      r_grant     <= 2'b00;
      r_link_up   <= 1'b0;
      r_enc_data  <= K28_5;
      r_enc_k     <= 1'b1;
    end else begin
      case (r_state)
        ST_ALIGN: begin
          r_enc_data <= K28_5;
          r_enc_k    <= 1'b1;
          if (r_align_cnt == c_align_end) begin
            r_state   <= ST_IDLE;
            r_link_up <= 1'b1;
          end else begin
            r_align_cnt <= r_align_cnt + c_align_one;
          end
        end
        ST_IDLE: begin
          r_enc_data <= K28_5;
          r_enc_k    <= 1'b1;
          if (|w_req) begin
            r_grant <= w_arb_grant;
            r_state <= ST_SOF;
          end
        end
        ST_SOF: begin
          r_enc_data <= K27_7;
          r_enc_k    <= 1'b1;
          r_byte_cnt <= '0;
          r_state    <= ST_DATA;
        end
        ST_DATA: begin
          if (w_accept) begin
            r_enc_data <= w_sel_data;
            r_enc_k    <= 1'b0;
            r_byte_cnt <= r_byte_cnt + c_cnt_one;
            // Either end of packet or the frame is full: close it.
            if (w_sel_last || (r_byte_cnt == c_cnt_end)) begin
              r_state <= ST_EOF;
            end
          end else begin
            r_enc_data <= K28_5;
            r_enc_k    <= 1'b1;
          end
        end
        ST_EOF: begin
          r_enc_data <= K29_7;
          r_enc_k    <= 1'b1;
          r_grant    <= 2'b00;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_ALIGN;
        end
      endcase
    end
  end

  assign enc_data = r_enc_data;
  assign enc_k    = r_enc_k;
  assign grant    = r_grant;
  assign link_up  = r_link_up;

endmodule

`default_nettype wire

// File: tb/tb_tx_link_sequencer.sv
// ============================================================================
// Module      : tb_tx_link_sequencer
// Description : Directed self-checking bench for tx_link_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_link_sequencer;

  localparam logic [7:0] c_bc = 8'hBC;
  localparam logic [7:0] c_fb = 8'hFB;
  localparam logic [7:0] c_fd = 8'hFD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] enc_data;
  logic       enc_k;
  logic [1:0] grant;
  logic       link_up;

  tx_link_sequencer #(.ALIGN_LEN(8), .MAX_FRAME(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .enc_data   (enc_data),
    .enc_k      (enc_k),
    .grant      (grant),
    .link_up    (link_up)
  );

  always #5 clk = ~clk;

  logic [8:0] q0[$], q1[$];   // {last, data} per pending byte
  logic [8:0] cap[$], exp_q[$];
  logic [1:0] gcap[$], rcap[$];
  logic       lcap[$];
  int sent0 = 0, gap_at0 = -1, gap_left0 = 0;
  int assert_cnt = 0, fail_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_cnt++;
    if (obs !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    logic hold0;
    hold0 = (sent0 == gap_at0) && (gap_left0 > 0);
    if (hold0) gap_left0--;
    req0_valid = (q0.size() > 0) && !hold0;
    req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req0_last  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
  endtask

  task automatic cycle();
    logic a0, a1;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    cap.push_back({enc_k, enc_data});
    gcap.push_back(grant);
    rcap.push_back({req1_ready, req0_ready});
    lcap.push_back(link_up);
    if (a0) begin void'(q0.pop_front()); sent0++; end
    if (a1) void'(q1.pop_front());
    drive();
  endtask

  task automatic exp_k(input logic [7:0] b); exp_q.push_back({1'b1, b}); endtask
  task automatic exp_d(input logic [7:0] b); exp_q.push_back({1'b0, b}); endtask

  task automatic run_cmp(input string tag);
    int n;
    n = exp_q.size();
    cap.delete(); gcap.delete(); rcap.delete(); lcap.delete();
    repeat (n) cycle();
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_sym%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    check_val("rst_data",   32'(enc_data),   32'hBC);
    check_val("rst_k",      32'(enc_k),      32'h1);
    check_val("rst_grant",  32'(grant),      32'h0);
    check_val("rst_linkup", 32'(link_up),    32'h0);
    check_val("rst_ready",  32'({req1_ready, req0_ready}), 32'h0);
    @(negedge clk) rst = 1'b1;

    // Alignment burst, link_up only after the 8th comma
    repeat (8) exp_k(c_bc);
    run_cmp("align");
    for (int i = 0; i < 8; i++)
      check_val($sformatf("align_linkup%0d", i), 32'(lcap[i]), (i == 7) ? 32'h1 : 32'h0);
    repeat (2) exp_k(c_bc);
    run_cmp("idle");

    // Single three-byte packet on ch0
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
    drive();
    exp_k(c_bc); exp_k(c_fb); exp_d(8'h11); exp_d(8'h22); exp_d(8'h33); exp_k(c_fd); exp_k(c_bc);
    run_cmp("t2");
    check_val("t2_grant_sof",  32'(gcap[0]), 32'h1);
    check_val("t2_grant_data", 32'(gcap[3]), 32'h1);
    check_val("t2_grant_eof",  32'(gcap[5]), 32'h0);

    // Both valid: priority moved to ch1 after serving ch0
    q0.push_back({1'b0, 8'h41}); q0.push_back({1'b1, 8'h42});
    q1.push_back({1'b1, 8'h51});
    drive();
    exp_k(c_bc); exp_k(c_fb); exp_d(8'h51); exp_k(c_fd);
    exp_k(c_bc); exp_k(c_fb); exp_d(8'h41); exp_d(8'h42); exp_k(c_fd); exp_k(c_bc);
    run_cmp("t3");
    check_val("t3_grant_first",  32'(gcap[0]), 32'h2);
    check_val("t3_grant_second", 32'(gcap[4]), 32'h1);

    // 20-byte stream on ch1: forced split after 16 bytes
    for (int i = 0; i < 20; i++) q1.push_back({(i == 19), 8'(8'h60 + i)});
    drive();
    exp_k(c_bc); exp_k(c_fb);
    for (int i = 0; i < 16; i++) exp_d(8'(8'h60 + i));
    exp_k(c_fd); exp_k(c_bc); exp_k(c_fb);
    for (int i = 16; i < 20; i++) exp_d(8'(8'h60 + i));
    exp_k(c_fd); exp_k(c_bc);
    run_cmp("t4");

    // last coincides with the 16th byte: exactly one EOF
    for (int i = 0; i < 16; i++) q0.push_back({(i == 15), 8'(8'h80 + i)});
    drive();
    exp_k(c_bc); exp_k(c_fb);
    for (int i = 0; i < 16; i++) exp_d(8'(8'h80 + i));
    exp_k(c_fd); exp_k(c_bc); exp_k(c_bc);
    run_cmp("t4b");

    // valid drops for two cycles after the second byte
    sent0 = 0; gap_at0 = 2; gap_left0 = 2;
    q0.push_back({1'b0, 8'h91}); q0.push_back({1'b0, 8'h92});
    q0.push_back({1'b0, 8'h93}); q0.push_back({1'b1, 8'h94});
    drive();
    exp_k(c_bc); exp_k(c_fb); exp_d(8'h91); exp_d(8'h92); exp_k(c_bc); exp_k(c_bc);
    exp_d(8'h93); exp_d(8'h94); exp_k(c_fd); exp_k(c_bc);
    run_cmp("t5");

    // Reset in the middle of a frame
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    drive();
    exp_k(c_bc); exp_k(c_fb); exp_d(8'hA1);
    run_cmp("t6");
    rst = 1'b0;
    #1;
    check_val("t6_rst_data",   32'(enc_data),   32'hBC);
    check_val("t6_rst_k",      32'(enc_k),      32'h1);
    check_val("t6_rst_grant",  32'(grant),      32'h0);
    check_val("t6_rst_linkup", 32'(link_up),    32'h0);
    check_val("t6_rst_ready",  32'(req0_ready), 32'h0);
    q0.delete(); q1.delete(); gap_at0 = -1;
    drive();
    @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Requests held through realignment; priority back to ch0
    q0.push_back({1'b1, 8'hC1});
    q1.push_back({1'b1, 8'hD1});
    drive();
    repeat (9) exp_k(c_bc);
    exp_k(c_fb); exp_d(8'hC1); exp_k(c_fd);
    exp_k(c_bc); exp_k(c_fb); exp_d(8'hD1); exp_k(c_fd); exp_k(c_bc);
    run_cmp("realign");
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("realign_ready%0d", i), 32'(rcap[i]), 32'h0);
      check_val($sformatf("realign_grant%0d", i), 32'(gcap[i]), 32'h0);
    end
    check_val("realign_linkup6", 32'(lcap[6]), 32'h0);
    check_val("realign_linkup7", 32'(lcap[7]), 32'h1);
    check_val("realign_grant_first", 32'(gcap[8]), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_link_sequencer.md
# tx_link_sequencer

Transmit-side scheduler in front of `encoder_8b10b`. It shares the encoder between two byte-stream requesters using round-robin arbitration and wraps each granted burst in K-code frame delimiters. It fills every other cycle with K28.5 comma/idle symbols and runs a comma alignment burst after reset. Exactly one symbol (byte plus K flag) is presented to the encoder every clock.

## Interface
- `ALIGN_LEN`, 8: K28.5 symbols emitted after reset before `link_up` (≥1).
- `MAX_FRAME`, 16: maximum data bytes per frame before forced EOF (≥1).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has a byte.
- `req0_data` / `req1_data`  in  8  requester byte.
- `req0_last` / `req1_last`  in  1  byte is last of the requester's packet.
- `req0_ready` / `req1_ready`  out  1  byte accepted when valid && ready.
- `enc_data`  out  8  symbol byte to the encoder (`data_in`).
- `enc_k`  out  1  1 = control symbol, 0 = data.
- `grant`  out  2  one-hot owner of the current frame; 0 when none.
- `link_up`  out  1  high once the alignment burst completes.

## Operation
- K-codes: K28.5 `8'hBC` is comma/idle. K27.7 `8'hFB` is SOF. K29.7 `8'hFD` is EOF.
- States: ALIGN, IDLE, SOF, DATA, EOF.
- ALIGN emits K28.5 for ALIGN_LEN cycles, then goes to IDLE and sets `link_up`=1. `link_up` stays 1 until reset.
- IDLE emits K28.5. If any `reqN_valid` is high, it arbitrates, latches `grant`, and goes to SOF. Otherwise it stays in IDLE.
- Arbitration is round-robin:
  - After reset, ch0 has priority.
  - After each EOF, priority goes to the channel that was not just served.
  - If only one channel is valid, that channel wins regardless of priority.
- SOF emits K27.7 for one cycle, clears the byte counter, and goes to DATA.
- DATA behaviour:
  - `reqN_ready` = (state==DATA) && grant[N]. This is combinational from state and grant only, never from valid.
  - On accept: `enc_data`<=byte, `enc_k`<=0, and the counter increments.
  - If the granted valid is low, emit K28.5 filler and stay in DATA (the frame remains open).
  - The non-granted requester is ignored and its ready stays 0.
- DATA→EOF on an accept with `last`=1, or on the accept that makes counter==MAX_FRAME (forced split). After a forced split, the requester's remaining bytes go in a later frame, subject to arbitration.
- EOF emits K29.7 for one cycle, updates priority, clears `grant`, and goes to IDLE. This guarantees at least one K28.5 between frames.
- The counter is $clog2(MAX_FRAME+1) bits wide and never wraps: the forced EOF fires exactly at MAX_FRAME.

## Timing
- Reset values (async assert): state=ALIGN, align counter=0, `enc_data`=8'hBC, `enc_k`=1, `grant`=0, `link_up`=0, both readies=0, priority=ch0.
- `enc_data`/`enc_k` are registered. The symbol for a cycle's state/accept appears after that cycle's rising edge, so latency from accept to encoder is 1 clock.
- Frame of N bytes with valid held high: 1 SOF + N data + 1 EOF + ≥1 idle. Earliest next SOF is 2 cycles after EOF (EOF cycle, IDLE cycle).
- `last` with counter==MAX_FRAME-1: a single EOF is emitted, no double EOF.
- `valid` dropping mid-frame: K28.5 filler is emitted; the byte count is unaffected.
- Both requesters assert in the same IDLE cycle: the priority holder wins, and the loser keeps valid high and is served next.
- Reset asserted mid-frame: immediate return to ALIGN with reset values. No EOF is sent; the frame is abandoned.
- Requests during ALIGN are not granted, and readies are 0.

## Structure
- Package `tx_link_pkg`: K-code constants (`K28_5`, `K27_7`, `K29_7`) and the state enum.
- One sub-module, `tx_rr_arb2`: 2-way round-robin arbiter with a priority register. Inputs are requests, an `update` strobe, and the served index. Output is the one-hot grant.
- All other logic lives in `tx_link_sequencer`: FSM, counters, and output registers.

## Test plan
- Reset, then no requests → 8 × (BC, k=1). `link_up` rises after the 8th; BC continues afterwards.
- req0 sends bytes 11, 22, 33 with last on 33 → BC, FB(k), 11, 22, 33 (k=0), FD(k), BC. `grant`=01 during the frame.
- req0 and req1 both valid in the same cycle after reset → ch0 frame first, then ch1 frame, with ≥1 BC between.
- req1 streams 20 bytes with no last, MAX_FRAME=16 → FB, 16 data bytes, FD, BC, FB, remaining 4 bytes, and so on.
- req0 valid drops for 2 cycles mid-frame → two BC fillers inside the frame, then data resumes and byte order is preserved.
- `rst` asserted during DATA → outputs immediately BC/k=1, `grant`=0, `link_up`=0. The ALIGN burst is repeated after release.
